mux_reg_8x8: RTL and testbench

//  Bank of eight 8-bit page registers with one-hot write enables and a one-hot
//  AND-OR read mux. Used as a byte-lane page register in the address/paging path.

---
 rtl/mux_reg_8x8_pkg.sv | 10 +
 rtl/mux_reg_cell.sv | 31 +++
 rtl/mux_reg_8x8.sv | 48 ++++
 tb/tb_mux_reg_8x8.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_reg_8x8_pkg.sv
// Shared constants and types for the eight-entry page register bank.
package mux_reg_8x8_pkg;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int CHAIN_LEN = WIDTH * DEPTH;

    typedef logic [WIDTH-1:0] page_byte_t;

endpackage

// File: rtl/mux_reg_cell.sv
// One WIDTH-bit page register with parallel load and a serial scan path.
module mux_reg_cell
    import mux_reg_8x8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       tc,
    input  logic       si,
    input  page_byte_t d,
    output page_byte_t q,
    output logic       so
);

    page_byte_t r_q;

    // Scan enters at bit 0 and leaves from the MSB; tc outranks load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (tc) begin
            r_q <= {r_q[WIDTH-2:0], si};
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q  = r_q;
    assign so = r_q[WIDTH-1];

endmodule

// File: rtl/mux_reg_8x8.sv
// Bank of eight scannable page registers with one-hot write enables and an
// AND-OR one-hot read mux; all 64 flops form a single scan chain td -> tq.
module mux_reg_8x8
    import mux_reg_8x8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DEPTH-1:0] en_in,
    input  logic [DEPTH-1:0] en_out,
    output logic [WIDTH-1:0] out_data,
    input  logic             tc,
    input  logic             td,
    output logic             tq
);

    page_byte_t       w_q      [DEPTH];
    page_byte_t       w_masked [DEPTH];
    logic [DEPTH:0]   w_chain;

    assign w_chain[0] = td;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        mux_reg_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (en_in[gi]),
            .tc    (tc),
            .si    (w_chain[gi]),
            .d     (in_data),
            .q     (w_q[gi]),
            .so    (w_chain[gi+1])
        );

        assign w_masked[gi] = w_q[gi] & {WIDTH{en_out[gi]}};
    end

    // Pure OR of masked terms: multiple selects merge, no select yields zero.
    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            out_data = out_data | w_masked[i];
        end
    end

    assign tq = w_chain[DEPTH];

endmodule

// File: tb/tb_mux_reg_8x8.sv
// Directed and randomized checks of mux_reg_8x8 against a 64-bit chain model.
module tb_mux_reg_8x8;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic [7:0] en_in;
    logic [7:0] en_out;
    logic [7:0] out_data;
    logic       tc;
    logic       td;
    logic       tq;

    int total;
    int bad;

    // Model: bit k of m_chain is reg[k/8][k%8]; scan shifts toward bit 63.
    logic [63:0] m_chain;

    mux_reg_8x8 dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .en_in    (en_in),
        .en_out   (en_out),
        .out_data (out_data),
        .tc       (tc),
        .td       (td),
        .tq       (tq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] m_read(input logic [7:0] sel);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++)
            if (sel[i]) r = r | m_chain[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Apply the model's edge rule to the current inputs, then cross the edge.
    task automatic tick();
        if (!reset) begin
            if (tc) begin
                m_chain = {m_chain[62:0], td};
            end else begin
                for (int i = 0; i < 8; i++)
                    if (en_in[i]) m_chain[i*8 +: 8] = in_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_out"}, out_data, m_read(en_out));
        chk({tag, "_tq"}, {7'd0, tq}, {7'd0, m_chain[63]});
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        m_chain = '0;
        #1;
        chk("rst_hold_out", out_data, m_read(en_out));
        tick();
        reset = 1'b0;
        #1;
    endtask

    logic [63:0] pat;

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        in_data = 8'h00;
        en_in   = 8'h00;
        en_out  = 8'hFF;
        tc      = 1'b0;
        td      = 1'b0;
        m_chain = '0;
        @(negedge clk);

        // 1: reset state
        reset = 1'b1;
        #1;
        chk("rst_out_during", out_data, 8'h00);
        chk("rst_tq_during", {7'd0, tq}, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_out_after", out_data, 8'h00);
        chk("rst_tq_after", {7'd0, tq}, 8'h00);

        // 2: single write and one-hot reads, write-through shows old value
        in_data = 8'hA5; en_in = 8'h08; en_out = 8'h08;
        #1;
        chk("wt_old_value", out_data, 8'h00);
        tick();
        en_in = 8'h00;
        #1;
        chk("rd_reg3", out_data, 8'hA5);
        en_out = 8'h04; #1; chk("rd_reg2", out_data, 8'h00);
        en_out = 8'h00; #1; chk("rd_none", out_data, 8'h00);

        // 3: OR of two registers, then broadcast write
        in_data = 8'h0F; en_in = 8'h02; tick();
        in_data = 8'hF0; en_in = 8'h40; tick();
        en_in = 8'h00;
        en_out = 8'h42; #1; chk("rd_or_1_6", out_data, 8'hFF);
        in_data = 8'h3C; en_in = 8'hFF; tick();
        en_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            en_out = 8'(1 << i);
            #1;
            chk("rd_bcast", out_data, 8'h3C);
        end

        // 4: single-bit latency through the chain; en_in ignored in scan
        do_reset();
        tc = 1'b1; en_in = 8'hFF; in_data = 8'hFF; en_out = 8'hFF; td = 1'b1;
        tick();
        td = 1'b0;
        chk("scan_no_load", out_data, 8'h01);
        for (int e = 2; e <= 65; e++) begin
            tick();
            chk("scan_lat_tq", {7'd0, tq}, (e == 64) ? 8'h01 : 8'h00);
            chk_model("scan_lat");
        end

        // 5: scan in 8'h5A per byte, read back, scan out
        do_reset();
        pat = {8{8'h5A}};
        tc = 1'b1; en_in = 8'h00;
        for (int k = 63; k >= 0; k--) begin
            td = pat[k];
            tick();
        end
        tc = 1'b0; td = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en_out = 8'(1 << i);
            #1;
            chk("scan_rd_5a", out_data, 8'h5A);
        end
        tc = 1'b1; en_out = 8'hFF;
        for (int j = 0; j < 64; j++) begin
            chk("scan_out_tq", {7'd0, tq}, {7'd0, pat[63-j]});
            tick();
        end
        chk("scan_out_empty", out_data, 8'h00);

        // 6: reset mid-scan clears at once, then chain stays zero
        tc = 1'b1;
        for (int e = 0; e < 30; e++) begin
            td = 1'($urandom_range(0, 1));
            tick();
        end
        td = 1'b1; tick(); td = 1'b0;
        #2;
        reset = 1'b1; m_chain = '0;
        #1;
        chk("midscan_rst_out", out_data, 8'h00);
        chk("midscan_rst_tq", {7'd0, tq}, 8'h00);
        tick();
        reset = 1'b0;
        td = 1'b0;
        for (int e = 0; e < 64; e++) begin
            tick();
            chk("post_rst_tq", {7'd0, tq}, 8'h00);
        end

        // Randomized mix against the model
        for (int n = 0; n < 400; n++) begin
            tc      = ($urandom_range(0, 3) == 0);
            td      = 1'($urandom_range(0, 1));
            en_in   = 8'($urandom);
            in_data = 8'($urandom);
            en_out  = 8'($urandom);
            #1;
            chk_model("rnd_pre");
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1; m_chain = '0;
                #1;
                chk_model("rnd_rst");
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
            chk_model("rnd_post");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
